// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the program counter, addresses the synchronous-read
// instruction memory and presents each fetched word to decode over a
// valid/ready handshake. Handles branch redirects and halt detection.
module fetch_sequencer #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      DEPTH      = 4,
  parameter int unsigned      START_ADDR = 0,
  parameter logic [WIDTH-1:0] HALT_INSTR = WIDTH'(8'hFF),
  localparam int unsigned     AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,            // asynchronous, active-low
  input  logic             start,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_instr,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [AW-1:0]    pc,
  input  logic             redirect,
  input  logic [AW-1:0]    redirect_addr,
  output logic             halted,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  // Start address folded into the legal range once, at elaboration.
  localparam logic [AW-1:0] START_PC = (START_ADDR < DEPTH) ? AW'(START_ADDR) : '0;

  state_e           state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;

  // Targets outside the populated range (possible only with a
  // non-power-of-2 DEPTH) restart fetch from address 0.
  function automatic logic [AW-1:0] legal_addr(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = a;
    if (32'(a) >= DEPTH) r = '0;
    return r;
  endfunction

  // Sequential successor, wrapping modulo DEPTH (also for non-power-of-2).
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = a + AW'(1);
    if (32'(a) >= DEPTH - 1) r = '0;
    return r;
  endfunction

  // State, PC and last-presented word registers; reset drops any pending word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state, PC and word-hold logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = START_PC;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // The memory registers the word for pc on the edge leaving REQ;
        // a redirect re-aims the request instead and stays here.
        if (redirect) begin
          pc_d = legal_addr(redirect_addr);
        end else begin
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        instr_d = mem_instr;
        if (redirect) begin
          pc_d    = legal_addr(redirect_addr);
          state_d = S_REQ;
        end else if (instr_ready) begin
          if (mem_instr == HALT_INSTR) begin
            state_d = S_HALT;
          end else begin
            pc_d    = next_addr(pc_q);
            state_d = S_REQ;
          end
        end
      end
      S_HALT: begin
        if (start) begin
          pc_d    = START_PC;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The memory output register already holds the word for pc throughout
  // VALID (pc and mem_addr do not move until the handshake), so it is the
  // presented instruction there; instr_q keeps the last word otherwise and
  // returns 0 immediately on reset.
  always_comb begin
    instr       = instr_q;
    instr_valid = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_REQ: begin
        busy = 1'b1;
      end
      S_VALID: begin
        instr       = mem_instr;
        instr_valid = 1'b1;
        busy        = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign pc       = pc_q;
  assign mem_addr = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a registered-read instruction memory.
module tb_fetch_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mem_addr;
  logic [7:0] mem_instr;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] pc;
  logic       redirect;
  logic [1:0] redirect_addr;
  logic       halted;
  logic       busy;

  logic [7:0] mem [0:3];
  logic [6:0] ctl;

  int checks   = 0;
  int failures = 0;

  fetch_sequencer #(.WIDTH(8), .DEPTH(4), .START_ADDR(0), .HALT_INSTR(8'hFF)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mem_addr      (mem_addr),
    .mem_instr     (mem_instr),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pc            (pc),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halted        (halted),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory: word appears one cycle after address.
  initial mem_instr = 8'h00;
  always @(posedge clk) mem_instr <= mem[mem_addr];

  assign ctl = {instr_valid, busy, halted, pc, mem_addr};

  function automatic logic [6:0] c_idle();
    return 7'b000_00_00;
  endfunction
  function automatic logic [6:0] c_req(input logic [1:0] p);
    return {3'b010, p, p};
  endfunction
  function automatic logic [6:0] c_vld(input logic [1:0] p);
    return {3'b110, p, p};
  endfunction
  function automatic logic [6:0] c_halt(input logic [1:0] p);
    return {3'b001, p, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    start         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 2'd0;
    instr_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    set_mem(8'h11, 8'h22, 8'h33, 8'h44);
    do_reset();
    checks++;
    if (ctl !== c_idle()) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=%b", ctl, c_idle());
    end
    checks++;
    if (instr !== 8'h00) begin
      failures++;
      $display("FAIL reset_instr got=%h exp=00", instr);
    end
  endtask

  task automatic test_sequential_wrap();
    logic [1:0] p;
    set_mem(8'h11, 8'h22, 8'h33, 8'h44);
    do_reset();
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (ctl !== c_req(2'd0)) begin
      failures++;
      $display("FAIL seq_first_req got=%b exp=%b", ctl, c_req(2'd0));
    end
    for (int i = 0; i < 5; i++) begin
      p = 2'(i % 4);
      tick();
      checks++;
      if (ctl !== c_vld(p) || instr !== mem[p]) begin
        failures++;
        $display("FAIL seq_valid_%0d got=%b/%h exp=%b/%h", i, ctl, instr, c_vld(p), mem[p]);
      end
      tick();
      checks++;
      if (ctl !== c_req(p + 2'd1)) begin
        failures++;
        $display("FAIL seq_gap_%0d got=%b exp=%b", i, ctl, c_req(p + 2'd1));
      end
    end
  endtask

  task automatic test_halt();
    set_mem(8'h11, 8'h22, 8'hFF, 8'h44);
    do_reset();
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ctl !== c_vld(2'(i)) || instr !== mem[i]) begin
        failures++;
        $display("FAIL halt_valid_%0d got=%b/%h exp=%b/%h", i, ctl, instr, c_vld(2'(i)), mem[i]);
      end
      tick();
    end
    checks++;
    if (ctl !== c_halt(2'd2)) begin
      failures++;
      $display("FAIL halt_state got=%b exp=%b", ctl, c_halt(2'd2));
    end
    redirect = 1'b1;
    redirect_addr = 2'd1;
    tick();
    tick();
    redirect = 1'b0;
    checks++;
    if (ctl !== c_halt(2'd2)) begin
      failures++;
      $display("FAIL halt_redirect_ignored got=%b exp=%b", ctl, c_halt(2'd2));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (ctl !== c_req(2'd0)) begin
      failures++;
      $display("FAIL halt_restart_req got=%b exp=%b", ctl, c_req(2'd0));
    end
    tick();
    checks++;
    if (ctl !== c_vld(2'd0) || instr !== 8'h11) begin
      failures++;
      $display("FAIL halt_restart_valid got=%b/%h exp=%b/11", ctl, instr, c_vld(2'd0));
    end
  endtask

  task automatic test_backpressure();
    set_mem(8'h11, 8'h22, 8'h33, 8'h44);
    do_reset();
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ctl !== c_vld(2'd1) || instr !== 8'h22) begin
        failures++;
        $display("FAIL bp_hold_%0d got=%b/%h exp=%b/22", i, ctl, instr, c_vld(2'd1));
      end
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++;
    if (ctl !== c_req(2'd2)) begin
      failures++;
      $display("FAIL bp_release got=%b exp=%b", ctl, c_req(2'd2));
    end
    tick();
    tick();
    checks++;
    if (ctl !== c_vld(2'd2) || instr !== 8'h33) begin
      failures++;
      $display("FAIL bp_next_word got=%b/%h exp=%b/33", ctl, instr, c_vld(2'd2));
    end
  endtask

  task automatic test_redirect();
    set_mem(8'h11, 8'h22, 8'h33, 8'h44);
    do_reset();
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (ctl !== c_vld(2'd0) || instr !== 8'h11) begin
      failures++;
      $display("FAIL redir_pre got=%b/%h exp=%b/11", ctl, instr, c_vld(2'd0));
    end
    redirect = 1'b1;
    redirect_addr = 2'd3;
    tick();
    redirect = 1'b0;
    checks++;
    if (ctl !== c_req(2'd3)) begin
      failures++;
      $display("FAIL redir_valid_req got=%b exp=%b", ctl, c_req(2'd3));
    end
    tick();
    checks++;
    if (ctl !== c_vld(2'd3) || instr !== 8'h44) begin
      failures++;
      $display("FAIL redir_valid_word got=%b/%h exp=%b/44", ctl, instr, c_vld(2'd3));
    end
    tick();
    checks++;
    if (ctl !== c_req(2'd0)) begin
      failures++;
      $display("FAIL redir_wrap_req got=%b exp=%b", ctl, c_req(2'd0));
    end
    redirect = 1'b1;
    redirect_addr = 2'd2;
    tick();
    redirect = 1'b0;
    checks++;
    if (ctl !== c_req(2'd2)) begin
      failures++;
      $display("FAIL redir_req_stay got=%b exp=%b", ctl, c_req(2'd2));
    end
    tick();
    checks++;
    if (ctl !== c_vld(2'd2) || instr !== 8'h33) begin
      failures++;
      $display("FAIL redir_req_word got=%b/%h exp=%b/33", ctl, instr, c_vld(2'd2));
    end
  endtask

  task automatic test_async_reset();
    set_mem(8'h11, 8'h22, 8'h33, 8'h44);
    do_reset();
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== c_idle() || instr !== 8'h00) begin
      failures++;
      $display("FAIL async_reset got=%b/%h exp=%b/00", ctl, instr, c_idle());
    end
    #2;
    rst = 1'b1;
    redirect = 1'b1;
    redirect_addr = 2'd2;
    tick();
    tick();
    redirect = 1'b0;
    checks++;
    if (ctl !== c_idle()) begin
      failures++;
      $display("FAIL idle_redirect_ignored got=%b exp=%b", ctl, c_idle());
    end
    instr_ready = 1'b0;
    start = 1'b1;
    tick();
    checks++;
    if (ctl !== c_req(2'd0)) begin
      failures++;
      $display("FAIL busy_start_req got=%b exp=%b", ctl, c_req(2'd0));
    end
    tick();
    tick();
    start = 1'b0;
    checks++;
    if (ctl !== c_vld(2'd0) || instr !== 8'h11) begin
      failures++;
      $display("FAIL busy_start_ignored got=%b/%h exp=%b/11", ctl, instr, c_vld(2'd0));
    end
  endtask

  initial begin
    rst           = 1'b0;
    start         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 2'd0;
    instr_ready   = 1'b0;
    test_reset();
    test_sequential_wrap();
    test_halt();
    test_backpressure();
    test_redirect();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
